fifo_rd_streamer: RTL and testbench

- Read-side drain engine for the dual-clock FIFO, running entirely in the read clock domain.
- Drives the FIFO read enable and captures the FIFO's registered read data, which appears one cycle after the read.
- Re-presents the data as a valid/ready stream with back-pressure, burst framing (last flag) and a delivered-beat counter.
- Sits between the FIFO read port and any downstream consumer (DMA, serialiser, checker).

---
 rtl/fifo_rd_streamer_pkg.sv | 6 +
 rtl/fifo_rd_streamer_skid_buf2.sv | 27 ++
 rtl/fifo_rd_streamer.sv | 63 ++++++
 tb/tb_fifo_rd_streamer.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/fifo_rd_streamer_pkg.sv
// fifo_rd_streamer_pkg: shared state encoding and default widths for the read-side streamer
package fifo_rd_streamer_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  localparam int DATA_WIDTH_DEF = 8;
  localparam int CNT_WIDTH_DEF = 32;
endpackage

// File: rtl/fifo_rd_streamer_skid_buf2.sv
// skid_buf2: two-entry register buffer, head in e0, simultaneous push and pop allowed
module skid_buf2 #(
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic [1:0]   occ
);
  logic [W-1:0] e0, e1;
  assign dout = e0;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ <= 2'd0;
      e0 <= '0;
      e1 <= '0;
    end else begin
      occ <= occ + {1'b0, push} - {1'b0, pop};
      if (pop && occ == 2'd2) e0 <= e1;
      else if (push && (occ == 2'd0 || pop)) e0 <= din;
      if (push && ((occ == 2'd1 && !pop) || (occ == 2'd2 && pop))) e1 <= din;
    end
  end
endmodule

// File: rtl/fifo_rd_streamer.sv
// fifo_rd_streamer: drains a registered-output FIFO into a valid/ready stream with burst framing
module fifo_rd_streamer
  import fifo_rd_streamer_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int BURST_LEN = 4,
  parameter int CNT_WIDTH = CNT_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  fifo_empty,
  output logic                  fifo_r_en,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  output logic                  busy,
  output logic [CNT_WIDTH-1:0]  beat_count
);
  localparam int IW = BURST_LEN > 1 ? $clog2(BURST_LEN) : 1;
  state_t state;
  logic inflight, pop, tag_last;
  logic [IW-1:0] idx;
  logic [1:0] occ;
  logic [DATA_WIDTH:0] head;
  assign pop = m_valid & m_ready;
  assign tag_last = idx == IW'(BURST_LEN - 1);
  assign fifo_r_en = ~fifo_empty & (state == RUN) &
                     ({1'b0, occ} + {2'b0, inflight} - {2'b0, pop} < 3'd2);
  assign m_valid = occ != 2'd0;
  assign {m_last, m_data} = head;
  assign busy = state != IDLE;
  skid_buf2 #(.W(DATA_WIDTH + 1)) u_skid (
    .clk  (clk),
    .rst  (rst),
    .push (inflight),
    .pop  (pop),
    .din  ({tag_last, fifo_data}),
    .dout (head),
    .occ  (occ)
  );
  // Beats leave in capture order, so counting captures yields the same index a pop counter would.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      inflight <= 1'b0;
      idx <= '0;
      beat_count <= '0;
    end else begin
      inflight <= fifo_r_en;
      if (inflight) idx <= tag_last ? '0 : idx + 1'b1;
      beat_count <= beat_count + CNT_WIDTH'(pop);
      case (state)
        IDLE:    state <= en ? RUN : IDLE;
        RUN:     state <= en ? RUN : DRAIN;
        DRAIN:   state <= en ? RUN : (occ == 2'd0 && !inflight) ? IDLE : DRAIN;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fifo_rd_streamer.sv
// tb_fifo_rd_streamer: directed stimulus against a behavioural FIFO, scoreboard-checked stream
module tb_fifo_rd_streamer;
  typedef struct {logic [7:0] d; logic l;} beat_t;
  logic clk = 1'b0, rst = 1'b1, en = 1'b0, m_ready = 1'b0, fifo_empty = 1'b1;
  logic fifo_r_en, m_valid, m_last, busy;
  logic [7:0] fifo_data = 8'h00, m_data;
  logic [31:0] beat_count;
  logic fifo_r_en4, m_valid4, m_last4, busy4;
  logic [7:0] m_data4;
  logic [3:0] beat_count4;
  logic [7:0] fifo_q[$];
  beat_t exp_q[$], e;
  int pop_cyc[$];
  int sb_idx = 0, tb_beats = 0, checks = 0, errors = 0, cyc = 0;
  logic stall = 1'b0, sl;
  logic [7:0] sd;
  logic [15:0] pat = 16'b0100_1110_0110_1001;

  fifo_rd_streamer #(.DATA_WIDTH(8), .BURST_LEN(4), .CNT_WIDTH(32)) u_dut (
    .clk(clk), .rst(rst), .en(en), .fifo_empty(fifo_empty), .fifo_r_en(fifo_r_en),
    .fifo_data(fifo_data), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .m_last(m_last), .busy(busy), .beat_count(beat_count)
  );
  fifo_rd_streamer #(.DATA_WIDTH(8), .BURST_LEN(4), .CNT_WIDTH(4)) u_dut4 (
    .clk(clk), .rst(rst), .en(en), .fifo_empty(fifo_empty), .fifo_r_en(fifo_r_en4),
    .fifo_data(fifo_data), .m_valid(m_valid4), .m_ready(m_ready), .m_data(m_data4),
    .m_last(m_last4), .busy(busy4), .beat_count(beat_count4)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst) begin
      fifo_q.delete();
      fifo_empty <= 1'b1;
      fifo_data <= 8'h00;
    end else begin
      if (fifo_r_en && !fifo_empty) fifo_data <= fifo_q.pop_front();
      fifo_empty <= (fifo_q.size() == 0);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    cyc++;
    if (rst) stall = 1'b0;
    else begin
      if (stall) begin
        chk("stable_valid", {31'd0, m_valid}, 32'd1);
        chk("stable_data", {24'd0, m_data}, {24'd0, sd});
        chk("stable_last", {31'd0, m_last}, {31'd0, sl});
      end
      if (fifo_r_en) chk("rd_while_empty", {31'd0, fifo_empty}, 32'd0);
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat: got %0h with none expected", m_data);
        end else begin
          e = exp_q.pop_front();
          chk("beat_data", {24'd0, m_data}, {24'd0, e.d});
          chk("beat_last", {31'd0, m_last}, {31'd0, e.l});
        end
        tb_beats++;
        pop_cyc.push_back(cyc);
      end
      stall = m_valid && !m_ready;
      sd = m_data;
      sl = m_last;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_word(input logic [7:0] d);
    fifo_q.push_back(d);
    exp_q.push_back('{d: d, l: (sb_idx == 3)});
    sb_idx = (sb_idx + 1) % 4;
  endtask

  task automatic wait_empty(input string name, input int max);
    int i = 0;
    while ((exp_q.size() != 0 || m_valid) && i < max) begin
      tick(1);
      i++;
    end
    chk(name, exp_q.size(), 0);
  endtask

  task automatic wait_idle(input string name, input int max);
    int i = 0;
    while (busy && i < max) begin
      tick(1);
      i++;
    end
    chk(name, {31'd0, busy}, 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    en = 1'b0;
    exp_q.delete();
    sb_idx = 0;
    tb_beats = 0;
    tick(2);
    rst = 1'b0;
    tick(1);
  endtask

  initial begin
    tick(2);
    chk("rst_valid", {31'd0, m_valid}, 32'd0);
    chk("rst_ren", {31'd0, fifo_r_en}, 32'd0);
    chk("rst_data", {24'd0, m_data}, 32'd0);
    chk("rst_last", {31'd0, m_last}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_count", beat_count, 32'd0);
    rst = 1'b0;
    tick(1);
    chk("release_ren", {31'd0, fifo_r_en}, 32'd0);
    // 8 beats at full rate
    pop_cyc.delete();
    for (int i = 1; i <= 8; i++) push_word(8'(i));
    en = 1'b1;
    m_ready = 1'b1;
    wait_empty("t1_drain", 40);
    chk("t1_count", beat_count, 32'd8);
    chk("t1_rate", pop_cyc.size() == 8 ? 32'(pop_cyc[7] - pop_cyc[0]) : 32'hffff_ffff, 32'd7);
    en = 1'b0;
    tick(4);
    chk("t1_idle", {31'd0, busy}, 32'd0);
    // back-pressure pattern
    for (int i = 1; i <= 6; i++) push_word(8'h10 + 8'(i));
    en = 1'b1;
    for (int i = 0; i < 80 && exp_q.size() != 0; i++) begin
      m_ready = pat[i % 16];
      tick(1);
    end
    m_ready = 1'b1;
    wait_empty("t2_drain", 20);
    chk("t2_count", beat_count, 32'd14);
    en = 1'b0;
    tick(4);
    // empty FIFO, then a single word mid-burst
    en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick(1);
      chk("t3_no_ren", {31'd0, fifo_r_en}, 32'd0);
      chk("t3_no_valid", {31'd0, m_valid}, 32'd0);
    end
    push_word(8'hA5);
    wait_empty("t3_drain", 20);
    chk("t3_count", beat_count, 32'd15);
    en = 1'b0;
    tick(4);
    do_reset();
    chk("t4_rst_count", beat_count, 32'd0);
    // stall with two buffered, then drop en while releasing ready
    m_ready = 1'b0;
    for (int i = 1; i <= 4; i++) push_word(8'h20 + 8'(i));
    en = 1'b1;
    tick(6);
    en = 1'b0;
    m_ready = 1'b1;
    wait_idle("t4_idle", 20);
    chk("t4_left", fifo_q.size(), 1);
    chk("t4_beats", tb_beats, 3);
    en = 1'b1;
    wait_empty("t4_resume", 20);
    chk("t4_count", beat_count, 32'd4);
    en = 1'b0;
    tick(4);
    // reset mid-stream
    for (int i = 1; i <= 5; i++) push_word(8'h30 + 8'(i));
    en = 1'b1;
    for (int i = 0; i < 30 && tb_beats < 6; i++) tick(1);
    chk("t5_started", tb_beats, 6);
    rst = 1'b1;
    #1;
    chk("t5_valid", {31'd0, m_valid}, 32'd0);
    chk("t5_data", {24'd0, m_data}, 32'd0);
    chk("t5_last", {31'd0, m_last}, 32'd0);
    chk("t5_ren", {31'd0, fifo_r_en}, 32'd0);
    chk("t5_busy", {31'd0, busy}, 32'd0);
    chk("t5_count", beat_count, 32'd0);
    chk("t5_count4", {28'd0, beat_count4}, 32'd0);
    exp_q.delete();
    sb_idx = 0;
    tb_beats = 0;
    en = 1'b0;
    tick(1);
    rst = 1'b0;
    tick(1);
    // 17 beats: narrow counter wraps through zero
    for (int i = 0; i < 17; i++) push_word(8'h40 + 8'(i));
    en = 1'b1;
    m_ready = 1'b1;
    wait_empty("t6_drain", 60);
    chk("t6_count", beat_count, 32'd17);
    chk("t6_count4", {28'd0, beat_count4}, 32'd1);
    en = 1'b0;
    wait_idle("t6_idle", 10);
    chk("sb_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
